// File: rtl/rc4_decryptor.sv
// RC4 PRGA: swaps entries of the shuffled S RAM, XORs the keystream with the encrypted ROM and writes the plaintext RAM.
// 10 cycles per byte. Optional plaintext range check behind `RC4_DECRYPT_CHECK_EN`.
module rc4_decryptor #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int MSG_LENGTH     = 32,
  parameter int MSG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      finished,
  output logic                      key_invalid,
  input  logic [DATA_WIDTH-1:0]     s_rdata,
  output logic [ADDR_WIDTH-1:0]     s_addr,
  output logic [DATA_WIDTH-1:0]     s_wdata,
  output logic                      s_we,
  input  logic [DATA_WIDTH-1:0]     msg_rdata,
  output logic [MSG_ADDR_WIDTH-1:0] msg_addr,
  output logic [MSG_ADDR_WIDTH-1:0] dec_addr,
  output logic [DATA_WIDTH-1:0]     dec_wdata,
  output logic                      dec_we
);

  typedef enum logic [3:0] {
    IDLE, RD_SI, WAIT_SI, GET_SI, WAIT_SJ, GET_SJ, WR_SJ,
    RD_F, WAIT_F, GET_F, WR_DEC, DONE
  } state_t;

  localparam logic [MSG_ADDR_WIDTH-1:0] LAST_K = MSG_ADDR_WIDTH'(MSG_LENGTH - 1);

  state_t                    state;
  logic                      start_q;
  logic                      start_rise;
  logic [ADDR_WIDTH-1:0]     i;
  logic [ADDR_WIDTH-1:0]     j;
  logic [MSG_ADDR_WIDTH-1:0] k;
  logic [DATA_WIDTH-1:0]     si;
  logic [DATA_WIDTH-1:0]     sj;
  logic [DATA_WIDTH-1:0]     dec_byte;

  assign start_rise = start & ~start_q;
  assign dec_byte   = s_rdata ^ msg_rdata;

`ifdef RC4_DECRYPT_CHECK_EN
  logic bad_q;
  logic legal;
  assign legal = ((dec_byte >= DATA_WIDTH'(8'h61)) && (dec_byte <= DATA_WIDTH'(8'h7A)))
              || (dec_byte == DATA_WIDTH'(8'h20));
`else
  assign key_invalid = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      si        <= '0;
      sj        <= '0;
      busy      <= 1'b0;
      finished  <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_we      <= 1'b0;
      msg_addr  <= '0;
      dec_addr  <= '0;
      dec_wdata <= '0;
      dec_we    <= 1'b0;
`ifdef RC4_DECRYPT_CHECK_EN
      bad_q       <= 1'b0;
      key_invalid <= 1'b0;
`endif
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          busy      <= 1'b0;
          finished  <= 1'b0;
          s_addr    <= '0;
          s_wdata   <= '0;
          s_we      <= 1'b0;
          msg_addr  <= '0;
          dec_addr  <= '0;
          dec_wdata <= '0;
          dec_we    <= 1'b0;
`ifdef RC4_DECRYPT_CHECK_EN
          key_invalid <= 1'b0;
          bad_q       <= 1'b0;
`endif
          if (start_rise) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            si    <= '0;
            sj    <= '0;
            busy  <= 1'b1;
            state <= RD_SI;
          end
        end
        RD_SI: begin
          i      <= i + ADDR_WIDTH'(1);
          s_addr <= i + ADDR_WIDTH'(1);
          s_we   <= 1'b0;
          state  <= WAIT_SI;
        end
        WAIT_SI: state <= GET_SI;
        GET_SI: begin
          si     <= s_rdata;
          j      <= j + ADDR_WIDTH'(s_rdata);
          s_addr <= j + ADDR_WIDTH'(s_rdata);
          state  <= WAIT_SJ;
        end
        WAIT_SJ: state <= GET_SJ;
        GET_SJ: begin
          sj      <= s_rdata;
          s_addr  <= i;
          s_wdata <= s_rdata;
          s_we    <= 1'b1;
          state   <= WR_SJ;
        end
        // When i==j this second write lands on the same word; si==sj so it is harmless.
        WR_SJ: begin
          s_addr  <= j;
          s_wdata <= si;
          s_we    <= 1'b1;
          state   <= RD_F;
        end
        RD_F: begin
          s_addr   <= ADDR_WIDTH'(si + sj);
          s_we     <= 1'b0;
          msg_addr <= k;
          state    <= WAIT_F;
        end
        WAIT_F: state <= GET_F;
        GET_F: begin
          dec_addr  <= k;
          dec_wdata <= dec_byte;
          dec_we    <= 1'b1;
`ifdef RC4_DECRYPT_CHECK_EN
          bad_q     <= ~legal;
`endif
          state     <= WR_DEC;
        end
        WR_DEC: begin
          dec_we <= 1'b0;
`ifdef RC4_DECRYPT_CHECK_EN
          if (bad_q || (k == LAST_K)) begin
            finished    <= 1'b1;
            key_invalid <= bad_q;
            state       <= DONE;
          end else begin
            k     <= k + MSG_ADDR_WIDTH'(1);
            state <= RD_SI;
          end
`else
          if (k == LAST_K) begin
            finished <= 1'b1;
            state    <= DONE;
          end else begin
            k     <= k + MSG_ADDR_WIDTH'(1);
            state <= RD_SI;
          end
`endif
        end
        DONE: begin
          finished  <= 1'b0;
          busy      <= 1'b0;
          s_addr    <= '0;
          s_wdata   <= '0;
          msg_addr  <= '0;
          dec_addr  <= '0;
          dec_wdata <= '0;
`ifdef RC4_DECRYPT_CHECK_EN
          key_invalid <= 1'b0;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
